// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access path.
//   - access size encodings (matching the decoder's inst_size field)
//   - access FSM state encoding
//   - byte-enable constants and small helpers for legality, enables and
//     store-lane replication
package mem_pkg;

  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] BYTE = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mau_state_e;

  // Natural alignment check; the reserved size code is never legal.
  function automatic logic size_aligned(input logic [1:0] size,
                                        input logic [1:0] offset);
    logic ok;
    case (size)
      WORD:    ok = (offset == 2'b00);
      HALF:    ok = ~offset[0];
      BYTE:    ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      WORD:    be = BE_WORD;
      HALF:    be = offset[1] ? (BE_HALF << 2) : BE_HALF;
      default: be = BE_BYTE << offset;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane so the memory only has
  // to honour the byte enables, not shift data.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      BYTE:    d = {4{wdata[7:0]}};
      HALF:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half lane out of a 32-bit read word
// and sign- or zero-extends it. Purely combinational so it can also sit in
// a fetch path.
//   rdata       in  32  raw bus read word
//   offset      in  2   byte offset within the word
//   size        in  2   WORD/HALF/BYTE
//   is_unsigned in  1   1 = zero-extend
//   data        out 32  aligned, extended result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[8*offset +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      BYTE:    data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      HALF:    data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I data-memory access unit. Turns decoded load/store
// controls into a single-outstanding req/ack bus transaction, and returns
// extended load data for write-back.
//   clk, reset                       clock, synchronous active-high reset
//   mem_read/mem_write/inst_size/
//   load_unsigned/addr/wdata/rd_in   request from execute
//   stall                            holds upstream stages (combinational)
//   load_valid/load_data/rd_out      completed load
//   access_err                       pulse: illegal request rejected
//   bus_err                          pulse: no ack within TIMEOUT
//   bus_req/bus_we/bus_addr/
//   bus_be/bus_wdata/bus_ack/
//   bus_rdata                        data bus
//
// state | meaning
// IDLE  | ready; accepts a legal request, rejects an illegal one
// WAIT  | bus_req high, waiting for bus_ack or timeout
// RESP  | load data registered; load_valid for one cycle
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic        access_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mau_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       offset_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [31:0]      align_data;
  logic             req, legal, accept, timeout;

  assign req    = mem_read | mem_write;
  assign legal  = size_aligned(inst_size, addr[1:0]) & ~(mem_read & mem_write);
  assign accept = (state == IDLE) & req & legal;
  // An ack on the terminal-count cycle still wins over the timeout.
  assign timeout = (state == WAIT) & ~bus_ack & (cnt == CNT_MAX);

  load_align u_load_align (
    .rdata       (bus_rdata),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (align_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = WAIT;
      WAIT: begin
        if (bus_ack)      state_nxt = bus_we ? IDLE : RESP;
        else if (timeout) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall      = accept | (state == WAIT) | (state == RESP);
  assign bus_req    = (state == WAIT);
  assign load_valid = (state == RESP);
  assign bus_err    = timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      offset_q   <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      access_err <= 1'b0;
      rd_out     <= '0;
      load_data  <= '0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      access_err <= (state == IDLE) & req & ~legal;
      if (accept) begin
        offset_q   <= addr[1:0];
        size_q     <= inst_size;
        unsigned_q <= load_unsigned;
        bus_we     <= mem_write;
        bus_addr   <= {addr[31:2], 2'b00};
        bus_be     <= byte_enables(inst_size, addr[1:0]);
        bus_wdata  <= store_lanes(inst_size, wdata);
        cnt        <= '0;
        if (mem_read) rd_out <= rd_in;
      end else if ((state == WAIT) && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == WAIT) && bus_ack && !bus_we) load_data <= align_data;
    end
  end

endmodule
